mp4_control_sequencer: RTL and testbench

//  Fetch/decode/execute controller for the 4-bit accumulator microprocessor datapath.

---
 rtl/mp4_ctrl_pkg.sv | 46 ++++
 rtl/mp4_op_decode.sv | 31 +++
 rtl/mp4_control_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mp4_control_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp4_ctrl_pkg.sv
// Shared types for the 4-bit accumulator controller: opcodes, FSM states,
// opcode classes and the internal-bus control bundle.
package mp4_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_OUT  = 4'b0011;
  localparam logic [3:0] OP_IN   = 4'b0100;
  localparam logic [3:0] OP_LOAD = 4'b0101;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EX1,
    ST_EX2,
    ST_IN_HS,
    ST_OUT_HS,
    ST_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , ST_STEP_WAIT
`endif
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_ALU,
    CL_LOAD,
    CL_OUT,
    CL_IN,
    CL_HLT
  } op_class_e;

  typedef struct packed {
    logic imm_oe;
    logic acc_oe;
    logic alu_oe;
    logic in_oe;
    logic acc_ld;
    logic b_ld;
    logic out_ld;
    logic alu_sub;
  } ctrl_t;

endpackage

// File: rtl/mp4_op_decode.sv
// Combinational opcode classifier; illegal opcodes are reported and
// otherwise treated as NOP.
module mp4_op_decode
  import mp4_ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output op_class_e  op_class_o,
  output logic       is_sub_o,
  output logic       illegal_o
);

  always_comb begin
    op_class_o = CL_NOP;
    is_sub_o   = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_i)
      OP_NOP:  op_class_o = CL_NOP;
      OP_ADD:  op_class_o = CL_ALU;
      OP_SUB: begin
        op_class_o = CL_ALU;
        is_sub_o   = 1'b1;
      end
      OP_OUT:  op_class_o = CL_OUT;
      OP_IN:   op_class_o = CL_IN;
      OP_LOAD: op_class_o = CL_LOAD;
      OP_HLT:  op_class_o = CL_HLT;
      default: illegal_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mp4_control_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit accumulator datapath.
// Optional single-step mode is enabled with the SEQ_SINGLE_STEP_EN macro.
module mp4_control_sequencer
  import mp4_ctrl_pkg::*;
#(
  parameter int PC_W     = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk1,
  input  logic            MainClear,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step_mode,
  input  logic            step,
`endif
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic            mem_ack,
  input  logic [7:0]      mem_data,
  output logic [3:0]      imm,
  output logic            imm_oe,
  output logic            acc_oe,
  output logic            alu_oe,
  output logic            in_oe,
  output logic            acc_ld,
  output logic            b_ld,
  output logic            out_ld,
  output logic            alu_sub,
  output logic            in_ready,
  input  logic            in_valid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted,
  output logic            mem_timeout,
  output logic            illegal_op
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      ir_q;
  logic [7:0]      wait_cnt_q;
  logic            out_valid_q;
  logic            halted_q;
  logic            mem_timeout_q;

  op_class_e op_class;
  logic      op_is_sub;
  logic      op_illegal;
  state_e    fetch_next;
  ctrl_t     ctrl;

  mp4_op_decode u_dec (
    .opcode_i   (ir_q[7:4]),
    .op_class_o (op_class),
    .is_sub_o   (op_is_sub),
    .illegal_o  (op_illegal)
  );

`ifdef SEQ_SINGLE_STEP_EN
  assign fetch_next = step_mode ? ST_STEP_WAIT : ST_FETCH;
`else
  assign fetch_next = ST_FETCH;
`endif

  always_ff @(posedge clk1) begin
    if (MainClear) begin
      state_q       <= ST_FETCH;
      pc_q          <= '0;
      ir_q          <= '0;
      wait_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      halted_q      <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (mem_ack) begin
            ir_q       <= mem_data;
            wait_cnt_q <= '0;
            state_q    <= ST_DECODE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q       <= ST_HALT;
            halted_q      <= 1'b1;
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ST_DECODE: begin
          pc_q <= pc_q + PC_W'(1);
          case (op_class)
            CL_NOP: state_q <= fetch_next;
            CL_HLT: begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end
            CL_IN:   state_q <= ST_IN_HS;
            default: state_q <= ST_EX1;
          endcase
        end
        ST_EX1: begin
          case (op_class)
            CL_ALU: state_q <= ST_EX2;
            CL_OUT: begin
              out_valid_q <= 1'b1;
              state_q     <= ST_OUT_HS;
            end
            default: state_q <= fetch_next;
          endcase
        end
        ST_EX2: state_q <= fetch_next;
        ST_IN_HS: begin
          if (in_valid) state_q <= fetch_next;
        end
        ST_OUT_HS: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= fetch_next;
          end
        end
        ST_HALT: state_q <= ST_HALT;
`ifdef SEQ_SINGLE_STEP_EN
        ST_STEP_WAIT: begin
          if (step) state_q <= ST_FETCH;
        end
`endif
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Bus enables decode from the registered state; only IN_HS looks at an input.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_EX1: begin
        case (op_class)
          CL_LOAD: begin
            ctrl.imm_oe = 1'b1;
            ctrl.acc_ld = 1'b1;
          end
          CL_ALU: begin
            ctrl.imm_oe  = 1'b1;
            ctrl.b_ld    = 1'b1;
            ctrl.alu_sub = op_is_sub;
          end
          CL_OUT: begin
            ctrl.acc_oe = 1'b1;
            ctrl.out_ld = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      ST_EX2: begin
        ctrl.alu_oe  = 1'b1;
        ctrl.acc_ld  = 1'b1;
        ctrl.alu_sub = op_is_sub;
      end
      ST_IN_HS: begin
        ctrl.in_oe  = in_valid;
        ctrl.acc_ld = in_valid;
      end
      default: ctrl = '0;
    endcase
  end

  assign mem_addr    = pc_q;
  assign mem_rd      = (state_q == ST_FETCH);
  assign imm         = ir_q[3:0];
  assign imm_oe      = ctrl.imm_oe;
  assign acc_oe      = ctrl.acc_oe;
  assign alu_oe      = ctrl.alu_oe;
  assign in_oe       = ctrl.in_oe;
  assign acc_ld      = ctrl.acc_ld;
  assign b_ld        = ctrl.b_ld;
  assign out_ld      = ctrl.out_ld;
  assign alu_sub     = ctrl.alu_sub;
  assign in_ready    = (state_q == ST_IN_HS);
  assign out_valid   = out_valid_q;
  assign halted      = halted_q;
  assign mem_timeout = mem_timeout_q;
  assign illegal_op  = (state_q == ST_DECODE) && op_illegal;

endmodule

// File: tb/tb_mp4_control_sequencer.sv
// Self-checking bench: each scenario builds a per-cycle expected trace in a
// queue, then the trace is replayed and compared against the sequencer.
module tb_mp4_control_sequencer;

  localparam logic [6:0] S_IMM   = 7'b1000000;
  localparam logic [6:0] S_ACC   = 7'b0100000;
  localparam logic [6:0] S_ALU   = 7'b0010000;
  localparam logic [6:0] S_IN    = 7'b0001000;
  localparam logic [6:0] S_ACCLD = 7'b0000100;
  localparam logic [6:0] S_BLD   = 7'b0000010;
  localparam logic [6:0] S_OUTLD = 7'b0000001;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [3:0] imm;
    logic [6:0] st;
    logic       sub;
    logic       inr;
    logic       ov;
    logic       hlt;
    logic       tmo;
    logic       ill;
  } obs_t;

  typedef struct packed {
    logic iv;
    logic ordy;
    obs_t o;
  } step_t;

  logic       clk1 = 1'b0;
  logic       MainClear;
  logic [3:0] mem_addr;
  logic       mem_rd, mem_ack;
  logic [7:0] mem_data;
  logic [3:0] imm;
  logic       imm_oe, acc_oe, alu_oe, in_oe, acc_ld, b_ld, out_ld, alu_sub;
  logic       in_ready, in_valid, out_valid, out_ready;
  logic       halted, mem_timeout, illegal_op;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
`endif

  logic [7:0] prog [16];
  logic       ack_en;

  int checks = 0;
  int errors = 0;

  step_t      sbq [$];
  logic [3:0] exp_pc, exp_imm;
  logic       exp_ov, exp_hlt, exp_tmo;

  assign mem_ack  = mem_rd & ack_en;
  assign mem_data = prog[mem_addr];

  always #5 clk1 = ~clk1;

  mp4_control_sequencer #(.PC_W(4), .WAIT_MAX(15)) dut (
    .clk1        (clk1),
    .MainClear   (MainClear),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .imm         (imm),
    .imm_oe      (imm_oe),
    .acc_oe      (acc_oe),
    .alu_oe      (alu_oe),
    .in_oe       (in_oe),
    .acc_ld      (acc_ld),
    .b_ld        (b_ld),
    .out_ld      (out_ld),
    .alu_sub     (alu_sub),
    .in_ready    (in_ready),
    .in_valid    (in_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .halted      (halted),
    .mem_timeout (mem_timeout),
    .illegal_op  (illegal_op)
  );

  task automatic do_reset();
    @(negedge clk1);
    MainClear = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    MainClear = 1'b0;
    ack_en    = 1'b1;
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    sbq.delete();
    exp_pc  = 4'd0;
    exp_imm = 4'd0;
    exp_ov  = 1'b0;
    exp_hlt = 1'b0;
    exp_tmo = 1'b0;
  endtask

  task automatic push_cyc(input logic rd, input logic [6:0] st, input logic sub,
                          input logic inr, input logic ill, input logic iv, input logic ordy);
    step_t e;
    e.iv     = iv;
    e.ordy   = ordy;
    e.o.rd   = rd;
    e.o.addr = exp_pc;
    e.o.imm  = exp_imm;
    e.o.st   = st;
    e.o.sub  = sub;
    e.o.inr  = inr;
    e.o.ov   = exp_ov;
    e.o.hlt  = exp_hlt;
    e.o.tmo  = exp_tmo;
    e.o.ill  = ill;
    sbq.push_back(e);
  endtask

  task automatic fetch_decode(input logic [3:0] op, input logic [3:0] operand, input logic ill);
    prog[exp_pc] = {op, operand};
    push_cyc(1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_imm = operand;
    push_cyc(1'b0, 7'd0, 1'b0, 1'b0, ill, 1'b0, 1'b0);
    exp_pc = exp_pc + 4'd1;
  endtask

  task automatic instr_load(input logic [3:0] v);
    fetch_decode(4'b0101, v, 1'b0);
    push_cyc(1'b0, S_IMM | S_ACCLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic instr_alu(input logic sub, input logic [3:0] v);
    fetch_decode(sub ? 4'b0010 : 4'b0001, v, 1'b0);
    push_cyc(1'b0, S_IMM | S_BLD, sub, 1'b0, 1'b0, 1'b0, 1'b0);
    push_cyc(1'b0, S_ALU | S_ACCLD, sub, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic instr_out(input int nwait);
    fetch_decode(4'b0011, 4'd0, 1'b0);
    push_cyc(1'b0, S_ACC | S_OUTLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_ov = 1'b1;
    for (int i = 0; i < nwait; i++) push_cyc(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_cyc(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_ov = 1'b0;
  endtask

  task automatic instr_in(input int nwait);
    fetch_decode(4'b0100, 4'd0, 1'b0);
    for (int i = 0; i < nwait; i++) push_cyc(1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_cyc(1'b0, S_IN | S_ACCLD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic push_fetch_only();
    push_cyc(1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_halt(input int n);
    for (int i = 0; i < n; i++) push_cyc(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_trace(input string name);
    int   n;
    step_t e;
    obs_t act;
    n = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      in_valid  = e.iv;
      out_ready = e.ordy;
      #1;
      act.rd   = mem_rd;
      act.addr = mem_addr;
      act.imm  = imm;
      act.st   = {imm_oe, acc_oe, alu_oe, in_oe, acc_ld, b_ld, out_ld};
      act.sub  = alu_sub;
      act.inr  = in_ready;
      act.ov   = out_valid;
      act.hlt  = halted;
      act.tmo  = mem_timeout;
      act.ill  = illegal_op;
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL %s cycle %0d: got rd/addr/imm/st/sub/inr/ov/hlt/tmo/ill=%b/%h/%h/%b/%b/%b/%b/%b/%b/%b want %b/%h/%h/%b/%b/%b/%b/%b/%b/%b",
                 name, n + 1,
                 act.rd, act.addr, act.imm, act.st, act.sub, act.inr, act.ov, act.hlt, act.tmo, act.ill,
                 e.o.rd, e.o.addr, e.o.imm, e.o.st, e.o.sub, e.o.inr, e.o.ov, e.o.hlt, e.o.tmo, e.o.ill);
      end
      n++;
      @(negedge clk1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    push_fetch_only();
    run_trace("reset");
  endtask

  task automatic test_load_add_out();
    do_reset();
    instr_load(4'd5);
    instr_alu(1'b0, 4'd3);
    instr_out(2);
    push_fetch_only();
    run_trace("load_add_out");
  endtask

  task automatic test_load_sub();
    do_reset();
    instr_load(4'd7);
    instr_alu(1'b1, 4'd2);
    push_fetch_only();
    run_trace("load_sub");
  endtask

  task automatic test_in_handshake();
    do_reset();
    instr_in(3);
    instr_in(0);
    push_fetch_only();
    run_trace("in_handshake");
  endtask

  task automatic test_pc_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) fetch_decode(4'b0000, 4'(i), 1'b0);
    push_fetch_only();
    run_trace("pc_wrap");
  endtask

  task automatic test_timeout();
    do_reset();
    ack_en = 1'b0;
    for (int i = 0; i < 15; i++) push_fetch_only();
    exp_hlt = 1'b1;
    exp_tmo = 1'b1;
    push_halt(4);
    run_trace("timeout");
  endtask

  task automatic test_illegal_hlt();
    do_reset();
    fetch_decode(4'b0111, 4'd9, 1'b1);
    fetch_decode(4'b1111, 4'd0, 1'b0);
    exp_hlt = 1'b1;
    push_halt(4);
    run_trace("illegal_hlt");
  endtask

  task automatic test_clear_in_out_hs();
    do_reset();
    instr_load(4'd4);
    fetch_decode(4'b0011, 4'd0, 1'b0);
    push_cyc(1'b0, S_ACC | S_OUTLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_ov = 1'b1;
    push_halt(2);
    run_trace("out_hs_pre_clear");
    MainClear = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk1);
    #1;
    MainClear = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mem_addr !== 4'd0 || mem_rd !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_out_hs: got out_valid=%b mem_addr=%h mem_rd=%b halted=%b want 0/0/1/0",
               out_valid, mem_addr, mem_rd, halted);
    end
  endtask

  initial begin
    MainClear = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ack_en    = 1'b1;
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    test_reset();
    test_load_add_out();
    test_load_sub();
    test_in_handshake();
    test_pc_wrap();
    test_timeout();
    test_illegal_hlt();
    test_clear_in_out_hs();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
